// File: rtl/bit_scan_encoder.sv
// rtl/bit_scan_encoder.sv - serialises a multi-hot request vector into set-bit indices, lowest first
// Optional popcount output is enabled by defining BIT_SCAN_COUNT_EN.
module bit_scan_encoder #(
  parameter int OUT_WIDTH = 5,
  parameter bit ACTIVE    = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(1<<OUT_WIDTH)-1:0]   in_vec,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [OUT_WIDTH-1:0]        out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy
`ifdef BIT_SCAN_COUNT_EN
  ,
  output logic [OUT_WIDTH:0]          count
`endif
);

  localparam int N = 1 << OUT_WIDTH;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state;
  logic [N-1:0]         pending;
  logic [N-1:0]         norm;
  logic [N-1:0]         rest;
  logic [OUT_WIDTH-1:0] low_idx;
  logic                 accept;
  logic                 scanning;

  assign norm     = ACTIVE ? in_vec : ~in_vec;
  // Clearing the lowest set bit leaves exactly the bits still owed after this beat.
  assign rest     = pending & (pending - ONE);
  assign scanning = (state == SCAN);
  assign accept   = in_valid && !scanning;

  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = OUT_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (norm != '0)) begin
            pending <= norm;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            pending <= rest;
            if (rest == '0) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

  assign in_ready  = !scanning;
  assign out_valid = scanning;
  assign busy      = scanning;
  assign out_idx   = scanning ? low_idx : '0;
  assign out_last  = scanning && (rest == '0);

`ifdef BIT_SCAN_COUNT_EN
  logic [OUT_WIDTH:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + {{OUT_WIDTH{1'b0}}, norm[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (accept) begin
      count <= pop;
    end
  end
`endif

endmodule

// File: tb/tb_bit_scan_encoder.sv
// tb/tb_bit_scan_encoder.sv - randomized scoreboard bench for bit_scan_encoder (both ACTIVE levels)
module tb_bit_scan_encoder;

  localparam int OW = 5;
  localparam int N  = 1 << OW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_vec;
  logic          in_valid;
  logic          out_ready;
  logic          sel;

  logic          hi_in_ready, hi_out_valid, hi_out_last, hi_busy;
  logic [OW-1:0] hi_out_idx;
  logic          lo_in_ready, lo_out_valid, lo_out_last, lo_busy;
  logic [OW-1:0] lo_out_idx;
  logic          o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [OW-1:0] o_out_idx;
`ifdef BIT_SCAN_COUNT_EN
  logic [OW:0]   hi_count, lo_count, o_count;
  assign o_count = sel ? lo_count : hi_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_scan_encoder #(.OUT_WIDTH(OW), .ACTIVE(1'b1)) dut_hi (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid && !sel),
    .in_ready  (hi_in_ready),
    .out_idx   (hi_out_idx),
    .out_valid (hi_out_valid),
    .out_ready (out_ready),
    .out_last  (hi_out_last),
    .busy      (hi_busy)
`ifdef BIT_SCAN_COUNT_EN
    , .count   (hi_count)
`endif
  );

  bit_scan_encoder #(.OUT_WIDTH(OW), .ACTIVE(1'b0)) dut_lo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid && sel),
    .in_ready  (lo_in_ready),
    .out_idx   (lo_out_idx),
    .out_valid (lo_out_valid),
    .out_ready (out_ready),
    .out_last  (lo_out_last),
    .busy      (lo_busy)
`ifdef BIT_SCAN_COUNT_EN
    , .count   (lo_count)
`endif
  );

  assign o_in_ready  = sel ? lo_in_ready  : hi_in_ready;
  assign o_out_valid = sel ? lo_out_valid : hi_out_valid;
  assign o_out_last  = sel ? lo_out_last  : hi_out_last;
  assign o_busy      = sel ? lo_busy      : hi_busy;
  assign o_out_idx   = sel ? lo_out_idx   : hi_out_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(o_in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
    check({tag, "_out_idx"},   32'(o_out_idx),   32'd0);
    check({tag, "_out_last"},  32'(o_out_last),  32'd0);
    check({tag, "_busy"},      32'(o_busy),      32'd0);
  endtask

  // Called at a negedge with the selected DUT idle; returns at a negedge with it idle again.
  task automatic run_vec(input logic [N-1:0] vec, input int stall_pct, input bit lo,
                         input int hold_idx);
    int           exp_q[$];
    logic [N-1:0] norm;
    int           guard;
    int           held;
    guard = 0;
    held  = 0;
    sel   = lo;
    norm  = lo ? ~vec : vec;
    for (int i = 0; i < N; i++) if (norm[i]) exp_q.push_back(i);
    #1;
    check("pre_in_ready", 32'(o_in_ready), 32'd1);
    in_vec   = vec;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef BIT_SCAN_COUNT_EN
    check("count", 32'(o_count), 32'(exp_q.size()));
`endif
    while (exp_q.size() > 0) begin
      check("out_valid", 32'(o_out_valid), 32'd1);
      check("busy",      32'(o_busy),      32'd1);
      check("in_ready",  32'(o_in_ready),  32'd0);
      check("out_idx",   32'(o_out_idx),   32'(exp_q[0]));
      check("out_last",  32'(o_out_last),  32'(exp_q.size() == 1));
      if (exp_q[0] == hold_idx && held < 3) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      in_valid = $urandom_range(1);
      in_vec   = $urandom;
      @(negedge clk);
      if (out_ready) void'(exp_q.pop_front());
      guard++;
      if (guard > 2000) begin
        check("scan_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_idle("post");
`ifdef BIT_SCAN_COUNT_EN
    check("count_hold", 32'(o_count), 32'($countones(norm)));
`endif
  endtask

  initial begin
    logic [N-1:0] v;
    rst_n     = 1'b0;
    in_vec    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sel       = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("rst_hi");
    sel = 1'b1;
    #1;
    check_idle("rst_lo");
`ifdef BIT_SCAN_COUNT_EN
    check("rst_count", 32'(o_count), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_vec(32'h8000_0011, 0, 1'b0, -1);
    run_vec(32'h8000_0011, 0, 1'b0, 4);
    run_vec(32'h0000_0000, 0, 1'b0, -1);
    run_vec(32'hFFFF_FFFE, 0, 1'b1, -1);
    run_vec(32'hFFFF_FFFF, 0, 1'b0, -1);
    run_vec(32'hFFFF_FFFF, 0, 1'b1, -1);
    run_vec(32'h8000_0000, 0, 1'b0, -1);

    // Reset in the middle of a scan of 0x106.
    sel = 1'b0;
    in_vec = 32'h0000_0106;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_idx0", 32'(o_out_idx), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_idx1", 32'(o_out_idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
`ifdef BIT_SCAN_COUNT_EN
    check("async_rst_count", 32'(o_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("after_rst");
    end

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(3))
        0: v = $urandom;
        1: v = $urandom & $urandom & $urandom;
        2: v = 32'd1 << $urandom_range(N - 1);
        default: v = ~($urandom & $urandom);
      endcase
      run_vec(v, $urandom_range(60), 1'($urandom_range(1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_scan_encoder.md
# bit_scan_encoder

Sequential inverse of the one-hot decoder: accepts a 2^OUT_WIDTH-bit request vector and emits, one per cycle, the binary index of every active bit, lowest index first. Used in the ALU datapath wherever a multi-hot flag or select vector must be turned back into register/lane indices, such as flag-to-index conversion and lane iteration. Input and output sides both use valid/ready handshakes, so the block stalls cleanly under backpressure.

## Interface
- OUT_WIDTH, 5, index width; input vector width is 1 << OUT_WIDTH
- ACTIVE, 1, input active level (1 = bit set means HIGH, 0 = bit set means LOW)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_vec  input  1<<OUT_WIDTH  request vector, sampled on accept
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector (IDLE)
- out_idx  output  OUT_WIDTH  index of current lowest pending bit
- out_valid  output  1  out_idx is valid
- out_ready  input  1  consumer takes out_idx
- out_last  output  1  current beat is the final index of the vector
- busy  output  1  scan in progress (SCAN state)
- count  output  OUT_WIDTH+1  popcount of last accepted vector (only with BIT_SCAN_COUNT_EN)

## Operation
- Normalisation: norm = (ACTIVE[0]) ? in_vec : ~in_vec.
- Pending register holds the bits still to be emitted. States: IDLE, SCAN.
- IDLE: in_ready=1, out_valid=0, busy=0.
  - On in_valid & in_ready with norm != 0: pending <= norm, go to SCAN.
  - On accept with norm == 0: the vector is consumed and the block stays in IDLE. No output beat is produced.
- SCAN: in_ready=0, out_valid=1, busy=1.
  - out_idx = index of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
  - On out_valid & out_ready: clear that bit in pending. If out_last, go to IDLE and pending becomes 0.
  - Without out_ready: pending, out_idx and out_last hold stable.
- out_idx, out_last, out_valid, in_ready and busy are decoded from registered state only. There is no combinational path from any input to any output.
- When out_valid=0, out_idx=0 and out_last=0.
- Reset (async, any time): state IDLE, pending 0, count 0. Any partially emitted vector is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_idx=0, out_last=0, busy=0, count=0.
- Latency: vector accepted at rising edge k → first out_valid at cycle k+1.
- Throughput: one index per cycle while out_ready=1.
- A vector with P set bits occupies SCAN for P cycles minimum.
- Last-beat handshake at edge m → in_ready=1 in cycle m+1. There is a one-cycle bubble between vectors.
- in_vec and in_valid are ignored while in SCAN.
- Width of out_idx is exactly OUT_WIDTH. Index 2^OUT_WIDTH-1 is representable and must not wrap.
- rst_n assertion forces the outputs to their reset values asynchronously. Release is synchronous to the next clk edge.

## Configuration
- BIT_SCAN_COUNT_EN defined:
  - Port count exists.
  - On every accept, count <= popcount(norm), including 0 for an all-inactive vector.
  - count holds its value until the next accept. Range is 0..2^OUT_WIDTH.
- Undefined: no count port and no popcount logic. All other behaviour is identical.

## Test plan
- Lowest-first ordering, no stall: OUT_WIDTH=5, ACTIVE=1, in_vec=32'h8000_0011, out_ready=1 → out_idx 0, 4, 31 on three consecutive cycles starting at k+1; out_last only on 31; in_ready=1 the cycle after; count=3 with the macro.
- Backpressure: same vector, out_ready held 0 for 3 cycles while out_idx=4 → out_idx=4 and out_last=0 stay stable; the sequence resumes with 31 and no index is lost or duplicated.
- Empty vector: in_vec=0, ACTIVE=1 → accepted, out_valid never rises, in_ready stays 1, count=0.
- Active-low input: ACTIVE=0, in_vec=32'hFFFF_FFFE → single beat out_idx=0, out_last=1; count=1.
- Full vector: in_vec=32'hFFFF_FFFF, ACTIVE=1, out_ready=1 → 32 beats 0..31 with out_last on 31; count=32 (6'b100000).
- Reset mid-scan: rst_n=0 after beat 0 of 32'h0000_0106 → out_valid, busy and out_idx go to 0 immediately. After release: IDLE, in_ready=1, no further beats until a new vector is accepted.
